dma_line_controller: RTL and testbench
======================================

# dma_line_controller

Line-transfer sequencer between the unified `Cache` DMA interface and a single 32-bit word-wide memory port. It arbitrates between the cache's line-fill request and its dirty-line eviction, and serialises each 512-bit line into 16 word beats. Fill beats are reassembled into a line and handed back with a valid pulse. It replaces the behavioural DMA model in the processor top level, port-compatible on the cache side.

## Interface
- `LINE_BITS`, 512, cache line width in bits.
- `WORD_BITS`, 32, memory port word width. `BEATS = LINE_BITS/WORD_BITS` (16) is derived, not overridable.
- `clk_i`  in  1  single clock; all logic on rising edge.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `addr_out_request_DMA_i`  in  32  fill line address.
- `request_DMA_i`  in  1  fill request, level; held until `request_valid_DMA_o`.
- `data_out_evict_DMA_i`  in  512  evicted line data.
- `addr_out_evict_DMA_i`  in  32  evicted line address.
- `evict_DMA_i`  in  1  eviction request, level; held until `evict_DMA_o`.
- `data_in_request_DMA_o`  out  512  assembled fill line.
- `addr_in_request_DMA_o`  out  32  line-aligned address of the returned fill.
- `request_valid_DMA_o`  out  1  one-cycle fill-complete pulse.
- `evict_DMA_o`  out  1  one-cycle eviction-complete pulse.
- `mem_req_o`  out  1  beat request.
- `mem_we_o`  out  1  1 = write beat, 0 = read beat.
- `mem_addr_o`  out  32  byte address of the beat.
- `mem_wdata_o`  out  32  write data.
- `mem_gnt_i`  in  1  beat accepted this cycle.
- `mem_rvalid_i`  in  1  read data valid; returns in issue order.
- `mem_rdata_i`  in  32  read data.
- `busy_o`  out  1  high in any state other than IDLE.

## Operation
- **States:** IDLE, EVICT, FILL, DONE_E, DONE_F.
- **IDLE:** samples `evict_DMA_i` and `request_DMA_i`.
  - Only one asserted: serve it.
  - Both asserted: evict first unless `last_evict` is set. `last_evict` is a one-bit flag, set on entering EVICT and cleared on entering FILL. This ordering keeps write-back ahead of the refill and stops an eviction stream from starving a fill.
  - On leaving IDLE: capture address with bits [5:0] forced to 0. For an eviction, also capture the 512-bit data. Clear the issue counter `icnt` and the response counter `rcnt` (5 bits each).
- **EVICT:**
  - `mem_req_o=1`, `mem_we_o=1`.
  - `mem_addr_o = base + 4*icnt`.
  - `mem_wdata_o = line[32*icnt +: 32]`.
  - `icnt` increments on `mem_gnt_i`. The request is held with stable address and data until granted.
  - When the grant for `icnt==15` arrives, go to DONE_E. Writes have no response.
- **FILL:**
  - `mem_req_o=1`, `mem_we_o=0`, same address rule, while `icnt<16`.
  - Each `mem_rvalid_i` writes `mem_rdata_i` into `line[32*rcnt +: 32]` and increments `rcnt`.
  - Grant and rvalid in the same cycle are both honoured.
  - After 16 grants, `mem_req_o=0`.
  - When the 16th rvalid arrives, go to DONE_F.
- **DONE_E:** `evict_DMA_o=1` for one cycle, then IDLE.
- **DONE_F:**
  - `request_valid_DMA_o=1` for one cycle, then IDLE.
  - `data_in_request_DMA_o` and `addr_in_request_DMA_o` hold the assembled line and its base address from DONE_F until the next fill completes.
- **Input sampling:** requester inputs are not sampled in EVICT, FILL or the DONE states. The requester drops its level at the edge ending the pulse, so IDLE never sees a stale request.
- **Stray responses:** `mem_rvalid_i` outside FILL is ignored. `mem_gnt_i` without `mem_req_o` is ignored.
- **Address wrap:** `base + 4*icnt` never carries out of bit 5, so no wrap handling is needed.

## Timing
- **Reset (asynchronous, any state):**
  - State goes to IDLE; all outputs go to 0, including the 512-bit data and 32-bit addresses; `last_evict=0`; counters are 0.
  - An in-flight memory transaction is abandoned. Late rvalids are dropped as stray responses.
- **Fill, best case** (grant every cycle, rvalid one cycle after grant):
  - IDLE sees the request in cycle 0.
  - Requests are issued in cycles 1–16 and rvalids arrive in cycles 2–17.
  - `request_valid_DMA_o` pulses in cycle 18.
- **Evict, best case:** IDLE in cycle 0, beats in cycles 1–16, `evict_DMA_o` in cycle 17.
- **Back-to-back:** minimum one IDLE cycle between transactions.
- **Stalls:** memory stalls (gnt low) extend the transaction without limit. Output addresses and data stay stable while `mem_req_o && !mem_gnt_i`.

## Test plan
- **Single fill:**
  - Stimulus: fill at 0x1234_5678; memory returns word i = 0xA000_0000+i.
  - Required: beats addressed 0x1234_5640…0x1234_567C; pulse in cycle 18; line word 0 = 0xA000_0000, word 15 = 0xA000_000F; address output 0x1234_5640.
- **Single evict:**
  - Stimulus: evict at 0x0000_0080 with line word i = i.
  - Required: 16 writes to 0x80…0xBC with wdata 0…15; `evict_DMA_o` in cycle 17; no read beats.
- **Simultaneous fill and evict after reset:**
  - Required: evict served first, then fill. Next simultaneous pair: fill first (alternation verified across 3 pairs).
- **Random grant stalls and rvalid gaps** (gnt 50%, rvalid latency 1–4):
  - Required: request held stable while ungranted; line correct; exactly one pulse.
- **Reset mid-fill** after 7 grants:
  - Required: all outputs 0 immediately; later stray rvalids ignored; a new fill afterwards completes correctly.
- **Stray `mem_rvalid_i` in IDLE** and during EVICT:
  - Required: no state change; no pulse; `rcnt` unchanged.

Source files
------------

// File: rtl/dma_line_controller.sv
// Line DMA sequencer: arbitrates the cache fill and evict requests and moves 512-bit lines over a 32-bit memory port.
// Latency: fill completes 18 cycles after IDLE samples the request, evict 17 cycles (no stalls); stalls add cycles one for one.
// Backpressure: a beat is held, with address and data stable, until mem_gnt_i; requester levels are held until their done pulse.
//
// Ports:
//   clk_i, rst_n_i                    clock, asynchronous active-low reset
//   addr_out_request_DMA_i, request_DMA_i
//                                     fill address and fill request level
//   data_out_evict_DMA_i, addr_out_evict_DMA_i, evict_DMA_i
//                                     evicted line, its address and evict request level
//   data_in_request_DMA_o, addr_in_request_DMA_o, request_valid_DMA_o
//                                     assembled fill line, its aligned address, completion pulse
//   evict_DMA_o                       eviction completion pulse
//   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_gnt_i
//                                     beat request channel
//   mem_rvalid_i, mem_rdata_i         in-order read responses
//   busy_o                            high whenever a transfer is in progress
module dma_line_controller #(
   parameter int LINE_BITS = 512,
   parameter int WORD_BITS = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [31:0]          addr_out_request_DMA_i,
   input  logic                 request_DMA_i,
   input  logic [LINE_BITS-1:0] data_out_evict_DMA_i,
   input  logic [31:0]          addr_out_evict_DMA_i,
   input  logic                 evict_DMA_i,
   output logic [LINE_BITS-1:0] data_in_request_DMA_o,
   output logic [31:0]          addr_in_request_DMA_o,
   output logic                 request_valid_DMA_o,
   output logic                 evict_DMA_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [31:0]          mem_addr_o,
   output logic [WORD_BITS-1:0] mem_wdata_o,
   input  logic                 mem_gnt_i,
   input  logic                 mem_rvalid_i,
   input  logic [WORD_BITS-1:0] mem_rdata_i,
   output logic                 busy_o
);

   localparam int BEATS      = LINE_BITS / WORD_BITS;
   localparam int IDX_W      = $clog2(BEATS);
   localparam int CNT_W      = IDX_W + 1;
   localparam int OFF_W      = $clog2(WORD_BITS / 8);
   localparam int ALIGN_W    = $clog2(LINE_BITS / 8);
   localparam logic [31:0] ALIGN_MASK = ~((32'd1 << ALIGN_W) - 32'd1);
   localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
   localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(BEATS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EVICT,
      ST_FILL,
      ST_DONE_E,
      ST_DONE_F
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     icnt_q, rcnt_q;
   logic [31:0]          base_q;
   logic [LINE_BITS-1:0] line_q;
   logic [LINE_BITS-1:0] line_wr;
   logic [LINE_BITS-1:0] fill_line_q;
   logic [31:0]          fill_addr_q;
   logic                 last_evict_q;

   logic                 pick_evict;
   logic                 start_evict;
   logic                 start_fill;
   logic                 issue_acc;
   logic                 rd_acc;
   logic [IDX_W-1:0]     icnt_idx;
   logic [IDX_W-1:0]     rcnt_idx;

   // An eviction wins a tie unless the previous transfer was itself an
   // eviction, so a stream of evictions cannot starve a pending fill.
   assign pick_evict  = evict_DMA_i && (!request_DMA_i || !last_evict_q);
   assign start_evict = (state_q == ST_IDLE) && pick_evict;
   assign start_fill  = (state_q == ST_IDLE) && !pick_evict && request_DMA_i;

   assign icnt_idx  = icnt_q[IDX_W-1:0];
   assign rcnt_idx  = rcnt_q[IDX_W-1:0];
   assign issue_acc = mem_req_o && mem_gnt_i;
   // Read data is only taken while a fill still expects words; anything
   // else on the response channel is a stray and is dropped.
   assign rd_acc    = (state_q == ST_FILL) && mem_rvalid_i && (rcnt_q < BEATS_C);

   // State register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_evict)         state_d = ST_EVICT;
            else if (request_DMA_i) state_d = ST_FILL;
         end
         ST_EVICT: begin
            if (mem_gnt_i && (icnt_q == LAST_C)) state_d = ST_DONE_E;
         end
         ST_FILL: begin
            if (rd_acc && (rcnt_q == LAST_C)) state_d = ST_DONE_F;
         end
         ST_DONE_E: state_d = ST_IDLE;
         ST_DONE_F: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      mem_req_o           = 1'b0;
      mem_we_o            = 1'b0;
      mem_addr_o          = 32'd0;
      mem_wdata_o         = '0;
      request_valid_DMA_o = 1'b0;
      evict_DMA_o         = 1'b0;
      busy_o              = (state_q != ST_IDLE);
      unique case (state_q)
         ST_EVICT: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = base_q + (32'(icnt_idx) << OFF_W);
            mem_wdata_o = line_q[WORD_BITS*icnt_idx +: WORD_BITS];
         end
         ST_FILL: begin
            if (icnt_q < BEATS_C) begin
               mem_req_o  = 1'b1;
               mem_addr_o = base_q + (32'(icnt_idx) << OFF_W);
            end
         end
         ST_DONE_E: evict_DMA_o         = 1'b1;
         ST_DONE_F: request_valid_DMA_o = 1'b1;
         default: ;
      endcase
   end

   // Line buffer with the incoming read word merged in; also what the
   // returned-fill register captures on the final word.
   always_comb begin
      line_wr = line_q;
      line_wr[WORD_BITS*rcnt_idx +: WORD_BITS] = mem_rdata_i;
   end

   // Datapath: counters, base address, working line, returned fill line
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         icnt_q       <= '0;
         rcnt_q       <= '0;
         base_q       <= 32'd0;
         line_q       <= '0;
         fill_line_q  <= '0;
         fill_addr_q  <= 32'd0;
         last_evict_q <= 1'b0;
      end else begin
         if (start_evict || start_fill) begin
            icnt_q       <= '0;
            rcnt_q       <= '0;
            last_evict_q <= start_evict;
            base_q       <= start_evict ? (addr_out_evict_DMA_i & ALIGN_MASK)
                                        : (addr_out_request_DMA_i & ALIGN_MASK);
         end
         if (start_evict) begin
            line_q <= data_out_evict_DMA_i;
         end
         if (issue_acc) begin
            icnt_q <= icnt_q + 1'b1;
         end
         if (rd_acc) begin
            line_q <= line_wr;
            rcnt_q <= rcnt_q + 1'b1;
            // The returned line only changes when a fill completes, so an
            // intervening eviction leaves the last fill result visible.
            if (rcnt_q == LAST_C) begin
               fill_line_q <= line_wr;
               fill_addr_q <= base_q;
            end
         end
      end
   end

   assign data_in_request_DMA_o = fill_line_q;
   assign addr_in_request_DMA_o = fill_addr_q;

endmodule

// File: tb/tb_dma_line_controller.sv
module tb_dma_line_controller;

   logic         clk_i = 1'b0;
   logic         rst_n_i = 1'b0;
   logic [31:0]  addr_out_request_DMA_i = '0;
   logic         request_DMA_i = 1'b0;
   logic [511:0] data_out_evict_DMA_i = '0;
   logic [31:0]  addr_out_evict_DMA_i = '0;
   logic         evict_DMA_i = 1'b0;
   logic [511:0] data_in_request_DMA_o;
   logic [31:0]  addr_in_request_DMA_o;
   logic         request_valid_DMA_o;
   logic         evict_DMA_o;
   logic         mem_req_o;
   logic         mem_we_o;
   logic [31:0]  mem_addr_o;
   logic [31:0]  mem_wdata_o;
   logic         mem_gnt_i = 1'b0;
   logic         mem_rvalid_i = 1'b0;
   logic [31:0]  mem_rdata_i = '0;
   logic         busy_o;

   dma_line_controller dut (
      .clk_i                  (clk_i),
      .rst_n_i                (rst_n_i),
      .addr_out_request_DMA_i (addr_out_request_DMA_i),
      .request_DMA_i          (request_DMA_i),
      .data_out_evict_DMA_i   (data_out_evict_DMA_i),
      .addr_out_evict_DMA_i   (addr_out_evict_DMA_i),
      .evict_DMA_i            (evict_DMA_i),
      .data_in_request_DMA_o  (data_in_request_DMA_o),
      .addr_in_request_DMA_o  (addr_in_request_DMA_o),
      .request_valid_DMA_o    (request_valid_DMA_o),
      .evict_DMA_o            (evict_DMA_o),
      .mem_req_o              (mem_req_o),
      .mem_we_o               (mem_we_o),
      .mem_addr_o             (mem_addr_o),
      .mem_wdata_o            (mem_wdata_o),
      .mem_gnt_i              (mem_gnt_i),
      .mem_rvalid_i           (mem_rvalid_i),
      .mem_rdata_i            (mem_rdata_i),
      .busy_o                 (busy_o)
   );

   initial forever #5 clk_i = ~clk_i;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // memory model controls
   bit gnt_rand = 1'b0;
   bit lat_rand = 1'b0;
   bit stray_en = 1'b0;
   int lat_fix = 1;
   logic [31:0] rd_words[16];

   // monitor state
   int          rsp_due[$];
   logic [31:0] rsp_dat[$];
   logic [31:0] beat_addr[$];
   logic        beat_we[$];
   logic [31:0] beat_wdata[$];
   int          order_q[$];     // 0 = eviction done, 1 = fill done
   int          fill_pulses = 0;
   int          evict_pulses = 0;
   int          fill_cyc = 0;
   int          evict_cyc = 0;
   logic [511:0] cap_data = '0;
   logic [31:0]  cap_addr = '0;
   int          stall_viol = 0;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [31:0] prev_wdata = '0;
   logic        prev_we = 1'b0;
   logic [511:0] fill_ref = '0;

   // Memory + monitor: acts 1 time unit after every rising edge.
   initial begin
      int lat;
      int due;
      forever begin
         @(posedge clk_i);
         #1;
         cyc++;
         if (request_valid_DMA_o) begin
            fill_pulses++;
            fill_cyc = cyc;
            cap_data = data_in_request_DMA_o;
            cap_addr = addr_in_request_DMA_o;
            order_q.push_back(1);
         end
         if (evict_DMA_o) begin
            evict_pulses++;
            evict_cyc = cyc;
            order_q.push_back(0);
         end
         if (prev_stall && rst_n_i) begin
            if (!mem_req_o || mem_addr_o !== prev_addr || mem_we_o !== prev_we ||
                (prev_we && mem_wdata_o !== prev_wdata))
               stall_viol++;
         end
         if (rsp_due.size() > 0 && rsp_due[0] <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = rsp_dat.pop_front();
            void'(rsp_due.pop_front());
         end else if (stray_en) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = $urandom;
         end else begin
            mem_rvalid_i = 1'b0;
         end
         mem_gnt_i = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         if (mem_req_o && mem_gnt_i) begin
            beat_addr.push_back(mem_addr_o);
            beat_we.push_back(mem_we_o);
            beat_wdata.push_back(mem_wdata_o);
            if (!mem_we_o) begin
               lat = lat_rand ? int'($urandom_range(1, 4)) : lat_fix;
               due = cyc + lat;
               if (rsp_due.size() > 0 && due <= rsp_due[$]) due = rsp_due[$] + 1;
               rsp_due.push_back(due);
               rsp_dat.push_back(rd_words[mem_addr_o[5:2]]);
            end
         end
         prev_stall = rst_n_i && mem_req_o && !mem_gnt_i;
         prev_addr  = mem_addr_o;
         prev_we    = mem_we_o;
         prev_wdata = mem_wdata_o;
      end
   end

   // ---------------- reference model helpers ----------------
   function automatic logic [31:0] align(input logic [31:0] a);
      return a & 32'hFFFF_FFC0;
   endfunction

   function automatic logic [511:0] memory_line();
      logic [511:0] l;
      for (int w = 0; w < 16; w++) l[32*w +: 32] = rd_words[w];
      return l;
   endfunction

   // Number of deviations of the logged beat sequence from one line transfer.
   function automatic int beat_errs(input logic [31:0] base, input bit we, input logic [511:0] d);
      int e = 0;
      if (beat_addr.size() != 16) return 100 + beat_addr.size();
      for (int w = 0; w < 16; w++) begin
         if (beat_addr[w] !== base + 32'(4 * w)) e++;
         if (beat_we[w] !== we) e++;
         if (we && beat_wdata[w] !== d[32*w +: 32]) e++;
      end
      return e;
   endfunction

   task automatic clear_logs();
      beat_addr.delete();
      beat_we.delete();
      beat_wdata.delete();
      order_q.delete();
      fill_pulses  = 0;
      evict_pulses = 0;
   endtask

   task automatic randomize_words();
      for (int w = 0; w < 16; w++) rd_words[w] = $urandom;
   endtask

   task automatic random_line(output logic [511:0] d);
      for (int w = 0; w < 16; w++) d[32*w +: 32] = $urandom;
   endtask

   task automatic apply_reset();
      @(posedge clk_i);
      #3 rst_n_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #3 rst_n_i = 1'b1;
   endtask

   // Raise one requester level, drop it in its completion-pulse cycle.
   task automatic run_xfer(input bit ev, input logic [31:0] a, input logic [511:0] d,
                           output int start, output bit ok);
      @(posedge clk_i);
      #2;
      if (ev) begin
         addr_out_evict_DMA_i = a;
         data_out_evict_DMA_i = d;
         evict_DMA_i = 1'b1;
      end else begin
         addr_out_request_DMA_i = a;
         request_DMA_i = 1'b1;
      end
      start = cyc;
      ok = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk_i);
         #2;
         if (ev ? evict_DMA_o : request_valid_DMA_o) begin
            ok = 1'b1;
            break;
         end
      end
      evict_DMA_i = 1'b0;
      request_DMA_i = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (3) @(posedge clk_i);
      #2;
      checks++;
      if ({mem_req_o, mem_we_o, busy_o, request_valid_DMA_o, evict_DMA_o} !== 5'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b want=00000",
                  {mem_req_o, mem_we_o, busy_o, request_valid_DMA_o, evict_DMA_o});
      end
      checks++;
      if (data_in_request_DMA_o !== '0 || addr_in_request_DMA_o !== 32'd0) begin
         failures++;
         $display("FAIL reset_fill_out data=%h addr=%h want 0", data_in_request_DMA_o, addr_in_request_DMA_o);
      end
      checks++;
      if (mem_addr_o !== 32'd0 || mem_wdata_o !== 32'd0) begin
         failures++;
         $display("FAIL reset_mem_out addr=%h wdata=%h want 0", mem_addr_o, mem_wdata_o);
      end
      #3 rst_n_i = 1'b1;
   endtask

   task automatic test_single_fill();
      int start;
      bit ok;
      gnt_rand = 0; lat_rand = 0; lat_fix = 1;
      for (int w = 0; w < 16; w++) rd_words[w] = 32'hA000_0000 + 32'(w);
      clear_logs();
      run_xfer(1'b0, 32'h1234_5678, '0, start, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL fill_timeout got=no pulse want=pulse"); end
      checks++;
      if (fill_cyc !== start + 18) begin
         failures++; $display("FAIL fill_pulse_cycle got=%0d want=%0d", fill_cyc - start, 18);
      end
      checks++;
      if (cap_data[31:0] !== 32'hA000_0000 || cap_data[511:480] !== 32'hA000_000F) begin
         failures++; $display("FAIL fill_words w0=%h w15=%h want A0000000/A000000F", cap_data[31:0], cap_data[511:480]);
      end
      checks++;
      if (cap_data !== memory_line()) begin
         failures++; $display("FAIL fill_line got=%h want=%h", cap_data, memory_line());
      end
      checks++;
      if (cap_addr !== 32'h1234_5640) begin
         failures++; $display("FAIL fill_addr got=%h want=12345640", cap_addr);
      end
      checks++;
      if (beat_errs(32'h1234_5640, 1'b0, '0) !== 0) begin
         failures++; $display("FAIL fill_beats errs=%0d want=0", beat_errs(32'h1234_5640, 1'b0, '0));
      end
      fill_ref = memory_line();
      repeat (4) @(posedge clk_i);
      #2;
      checks++;
      if (data_in_request_DMA_o !== fill_ref || fill_pulses !== 1) begin
         failures++; $display("FAIL fill_hold pulses=%0d data=%h want 1 pulse and held line", fill_pulses, data_in_request_DMA_o);
      end
   endtask

   task automatic test_single_evict();
      int start;
      bit ok;
      logic [511:0] d;
      for (int w = 0; w < 16; w++) d[32*w +: 32] = 32'(w);
      clear_logs();
      run_xfer(1'b1, 32'h0000_0080, d, start, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL evict_timeout got=no pulse want=pulse"); end
      checks++;
      if (evict_cyc !== start + 17) begin
         failures++; $display("FAIL evict_pulse_cycle got=%0d want=%0d", evict_cyc - start, 17);
      end
      checks++;
      if (beat_errs(32'h0000_0080, 1'b1, d) !== 0) begin
         failures++; $display("FAIL evict_beats errs=%0d want=0", beat_errs(32'h0000_0080, 1'b1, d));
      end
      checks++;
      if (fill_pulses !== 0 || data_in_request_DMA_o !== fill_ref) begin
         failures++; $display("FAIL evict_fill_side pulses=%0d data=%h want 0 and previous fill", fill_pulses, data_in_request_DMA_o);
      end
   endtask

   task automatic test_arbitration();
      bit last_ev;
      int start;
      bit ok, e_done, f_done;
      logic [511:0] d;
      logic [31:0] fa, ea;
      int want_first;
      apply_reset();
      last_ev = 0;
      for (int p = 0; p < 3; p++) begin
         if (p > 0) begin
            // Lone transfer before the pair sets which side the tie favours.
            random_line(d);
            randomize_words();
            run_xfer(p == 1, $urandom, d, start, ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL arb_lone_timeout pair=%0d", p); end
            last_ev = (p == 1);
         end
         clear_logs();
         randomize_words();
         random_line(d);
         fa = $urandom;
         ea = $urandom;
         want_first = last_ev ? 1 : 0;
         @(posedge clk_i);
         #2;
         addr_out_request_DMA_i = fa;
         addr_out_evict_DMA_i = ea;
         data_out_evict_DMA_i = d;
         request_DMA_i = 1'b1;
         evict_DMA_i = 1'b1;
         e_done = 0; f_done = 0;
         for (int i = 0; i < 500; i++) begin
            @(posedge clk_i);
            #2;
            if (evict_DMA_o) begin evict_DMA_i = 1'b0; e_done = 1; end
            if (request_valid_DMA_o) begin request_DMA_i = 1'b0; f_done = 1; end
            if (e_done && f_done) break;
         end
         evict_DMA_i = 1'b0;
         request_DMA_i = 1'b0;
         checks++;
         if (!(e_done && f_done) || order_q.size() != 2) begin
            failures++; $display("FAIL arb_pair_done pair=%0d evict=%0d fill=%0d want both", p, e_done, f_done);
         end else begin
            checks++;
            if (order_q[0] !== want_first || order_q[1] !== 1 - want_first) begin
               failures++; $display("FAIL arb_order pair=%0d got=%0d,%0d want=%0d,%0d", p, order_q[0], order_q[1], want_first, 1 - want_first);
            end
            last_ev = (order_q[1] == 0);
         end
         checks++;
         if (cap_data !== memory_line() || cap_addr !== align(fa)) begin
            failures++; $display("FAIL arb_fill_line pair=%0d addr=%h want=%h", p, cap_addr, align(fa));
         end
      end
   endtask

   task automatic test_random_stalls();
      int start;
      bit ok, ev;
      logic [511:0] d;
      logic [31:0] a;
      gnt_rand = 1; lat_rand = 1;
      stall_viol = 0;
      for (int it = 0; it < 6; it++) begin
         ev = 1'($urandom_range(0, 1));
         a = $urandom;
         random_line(d);
         randomize_words();
         clear_logs();
         run_xfer(ev, a, d, start, ok);
         repeat (3) @(posedge clk_i);
         #2;
         checks++;
         if (!ok) begin failures++; $display("FAIL rnd_timeout it=%0d evict=%0d", it, ev); end
         checks++;
         if (fill_pulses !== (ev ? 0 : 1) || evict_pulses !== (ev ? 1 : 0)) begin
            failures++; $display("FAIL rnd_pulses it=%0d fill=%0d evict=%0d want exactly one of kind evict=%0d", it, fill_pulses, evict_pulses, ev);
         end
         checks++;
         if (beat_errs(align(a), ev, d) !== 0) begin
            failures++; $display("FAIL rnd_beats it=%0d errs=%0d want=0", it, beat_errs(align(a), ev, d));
         end
         if (!ev) begin
            checks++;
            if (cap_data !== memory_line() || cap_addr !== align(a)) begin
               failures++; $display("FAIL rnd_fill_line it=%0d addr=%h want=%h", it, cap_addr, align(a));
            end
         end
      end
      checks++;
      if (stall_viol !== 0) begin
         failures++; $display("FAIL rnd_stall_stable violations=%0d want=0", stall_viol);
      end
      gnt_rand = 0; lat_rand = 0;
   endtask

   task automatic test_reset_mid_fill();
      int start;
      bit ok;
      lat_fix = 4;
      randomize_words();
      clear_logs();
      @(posedge clk_i);
      #2;
      addr_out_request_DMA_i = $urandom;
      request_DMA_i = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk_i);
         #3;
         if (beat_addr.size() >= 7) break;
      end
      @(posedge clk_i);
      #3;
      rst_n_i = 1'b0;
      request_DMA_i = 1'b0;
      #1;
      checks++;
      if ({mem_req_o, mem_we_o, busy_o, request_valid_DMA_o, evict_DMA_o} !== 5'b0 ||
          mem_addr_o !== 32'd0 || mem_wdata_o !== 32'd0) begin
         failures++; $display("FAIL midrst_ctrl req=%b busy=%b addr=%h want 0", mem_req_o, busy_o, mem_addr_o);
      end
      checks++;
      if (data_in_request_DMA_o !== '0 || addr_in_request_DMA_o !== 32'd0) begin
         failures++; $display("FAIL midrst_fill_out addr=%h want 0", addr_in_request_DMA_o);
      end
      repeat (2) @(posedge clk_i);
      #3 rst_n_i = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk_i);
         #2;
         if (rsp_due.size() == 0) break;
      end
      repeat (2) @(posedge clk_i);
      #2;
      checks++;
      if (rsp_due.size() != 0 || fill_pulses !== 0 || busy_o !== 1'b0) begin
         failures++; $display("FAIL midrst_stray pending=%0d pulses=%0d busy=%b want 0/0/0", rsp_due.size(), fill_pulses, busy_o);
      end
      lat_fix = 1;
      randomize_words();
      clear_logs();
      run_xfer(1'b0, 32'hCAFE_0104, '0, start, ok);
      checks++;
      if (!ok || cap_data !== memory_line() || cap_addr !== 32'hCAFE_0100 || fill_cyc !== start + 18) begin
         failures++; $display("FAIL midrst_refill ok=%0d addr=%h cyc=%0d want addr=cafe0100 cyc=18", ok, cap_addr, fill_cyc - start);
      end
   endtask

   task automatic test_stray_rvalid();
      int start;
      bit ok, busy_seen;
      logic [511:0] d;
      clear_logs();
      stray_en = 1;
      busy_seen = 0;
      repeat (10) begin
         @(posedge clk_i);
         #2;
         if (busy_o) busy_seen = 1;
      end
      checks++;
      if (busy_seen || fill_pulses !== 0 || evict_pulses !== 0) begin
         failures++; $display("FAIL stray_idle busy=%0d fill=%0d evict=%0d want 0", busy_seen, fill_pulses, evict_pulses);
      end
      random_line(d);
      run_xfer(1'b1, 32'h0000_4000, d, start, ok);
      checks++;
      if (!ok || evict_cyc !== start + 17 || beat_errs(32'h0000_4000, 1'b1, d) !== 0 || fill_pulses !== 0) begin
         failures++; $display("FAIL stray_evict ok=%0d cyc=%0d fill=%0d want cyc=17 fill=0", ok, evict_cyc - start, fill_pulses);
      end
      stray_en = 0;
      randomize_words();
      clear_logs();
      run_xfer(1'b0, 32'h0000_4040, '0, start, ok);
      checks++;
      if (!ok || cap_data !== memory_line() || fill_cyc !== start + 18) begin
         failures++; $display("FAIL stray_refill ok=%0d cyc=%0d line=%h want=%h", ok, fill_cyc - start, cap_data, memory_line());
      end
   endtask

   initial begin
      test_reset();
      test_single_fill();
      test_single_evict();
      test_arbitration();
      test_random_stalls();
      test_reset_mid_fill();
      test_stray_rvalid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
